// File: rtl/butterfly_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : butterfly_stage_if
// Brief    : Read-issue / write-back bus between FFT memory and butterfly stage.
// Revision : 1.0
// ============================================================================
interface butterfly_stage_if #(
    parameter int ADDR_SIZE  = 5,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_SIZE   = 8
);
    logic                    i_rden;
    logic [ADDR_SIZE-1:0]    i_rdaddr_A;
    logic [ADDR_SIZE-1:0]    i_rdaddr_B;
    logic [2*DATA_WIDTH-1:0] i_data_A;
    logic [2*DATA_WIDTH-1:0] i_data_B;
    logic [2*DATA_WIDTH-1:0] i_twiddle;
    logic                    o_wren;
    logic [ADDR_SIZE-1:0]    o_wraddr_A;
    logic [ADDR_SIZE-1:0]    o_wraddr_B;
    logic [2*DATA_WIDTH-1:0] o_wrdata_A;
    logic [2*DATA_WIDTH-1:0] o_wrdata_B;
    logic                    o_busy;
    logic [CNT_SIZE-1:0]     o_bfly_count;

    modport slave (
        input  i_rden, i_rdaddr_A, i_rdaddr_B, i_data_A, i_data_B, i_twiddle,
        output o_wren, o_wraddr_A, o_wraddr_B, o_wrdata_A, o_wrdata_B,
        output o_busy, o_bfly_count
    );

    modport master (
        output i_rden, i_rdaddr_A, i_rdaddr_B, i_data_A, i_data_B, i_twiddle,
        input  o_wren, o_wraddr_A, o_wraddr_B, o_wrdata_A, o_wrdata_B,
        input  o_busy, o_bfly_count
    );
endinterface
`default_nettype wire

// File: rtl/butterfly_stage.sv
`default_nettype none
// ============================================================================
// Module   : butterfly_stage
// Brief    : Fixed-latency radix-2 DIT butterfly, X/Y = (A +/- B*W)/2.
// Revision : 1.0
// ============================================================================
module butterfly_stage #(
    parameter int ADDR_SIZE   = 5,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_LATENCY = 1,
    parameter int CNT_SIZE    = 8
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    butterfly_stage_if.slave    bus
);
    localparam int c_DEPTH = MEM_LATENCY + 3;
    localparam int c_DW    = DATA_WIDTH;
    localparam int c_PW    = 2 * DATA_WIDTH;
    localparam logic [c_PW:0] c_RND =
        {{(c_PW - c_DW + 2){1'b0}}, 1'b1, {(c_DW - 2){1'b0}}};

    logic [c_DEPTH-1:0]    r_vld;
    logic [c_DEPTH:0]      w_vld;
    logic [ADDR_SIZE-1:0]  r_addr_a [c_DEPTH-1];
    logic [ADDR_SIZE-1:0]  r_addr_b [c_DEPTH-1];

    logic signed [c_DW-1:0] w_br, w_bi, w_wr, w_wi;
    logic [c_PW-1:0]        r_p1_a, r_p2_a;
    logic signed [c_PW-1:0] r_p1_rr, r_p1_ii, r_p1_ri, r_p1_ir;
    logic [c_PW:0]          w_bwr_rnd, w_bwi_rnd;
    logic [c_DW:0]          r_p2_bwr, r_p2_bwi;
    logic                   w_unused_bits;

    logic [ADDR_SIZE-1:0]  r_wraddr_a, r_wraddr_b;
    logic [c_PW-1:0]       r_wrdata_a, r_wrdata_b;
    logic [CNT_SIZE-1:0]   r_count;

    // Index k of w_vld is the issue strobe delayed by k cycles.
    assign w_vld = {r_vld, bus.i_rden};

    assign w_br = bus.i_data_B[c_PW-1:c_DW];
    assign w_bi = bus.i_data_B[c_DW-1:0];
    assign w_wr = bus.i_twiddle[c_PW-1:c_DW];
    assign w_wi = bus.i_twiddle[c_DW-1:0];

    // Round-half-up of the Q2.(2*DW-2) complex product back to DW+1 bits.
    assign w_bwr_rnd = {r_p1_rr[c_PW-1], r_p1_rr} - {r_p1_ii[c_PW-1], r_p1_ii} + c_RND;
    assign w_bwi_rnd = {r_p1_ri[c_PW-1], r_p1_ri} + {r_p1_ir[c_PW-1], r_p1_ir} + c_RND;
    assign w_unused_bits = ^{w_bwr_rnd[c_PW], w_bwr_rnd[c_DW-2:0],
                             w_bwi_rnd[c_PW], w_bwi_rnd[c_DW-2:0]};

    function automatic logic [c_DW-1:0] f_half_sat(
        input logic [c_DW-1:0] a,
        input logic [c_DW:0]   bw,
        input logic            sub
    );
        logic [c_DW+1:0] v_a, v_b, v_s, v_h;
        v_a = {{2{a[c_DW-1]}}, a};
        v_b = {bw[c_DW], bw};
        v_s = (sub ? (v_a - v_b) : (v_a + v_b)) + 1'b1;
        v_h = $signed(v_s) >>> 1;
        if (v_h[c_DW+1:c_DW-1] == 3'b000 || v_h[c_DW+1:c_DW-1] == 3'b111)
            return v_h[c_DW-1:0];
        return v_h[c_DW+1] ? {1'b1, {(c_DW-1){1'b0}}} : {1'b0, {(c_DW-1){1'b1}}};
    endfunction

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_vld <= '0;
            for (int i = 0; i < c_DEPTH - 1; i++) begin
                r_addr_a[i] <= '0;
                r_addr_b[i] <= '0;
            end
        end else begin
            r_vld       <= {r_vld[c_DEPTH-2:0], bus.i_rden};
            r_addr_a[0] <= bus.i_rdaddr_A;
            r_addr_b[0] <= bus.i_rdaddr_B;
            for (int i = 1; i < c_DEPTH - 1; i++) begin
                r_addr_a[i] <= r_addr_a[i-1];
                r_addr_b[i] <= r_addr_b[i-1];
            end
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_p1_a   <= '0;
            r_p1_rr  <= '0;
            r_p1_ii  <= '0;
            r_p1_ri  <= '0;
            r_p1_ir  <= '0;
            r_p2_a   <= '0;
            r_p2_bwr <= '0;
            r_p2_bwi <= '0;
        end else begin
            if (w_vld[MEM_LATENCY]) begin
                r_p1_a  <= bus.i_data_A;
                r_p1_rr <= w_br * w_wr;
                r_p1_ii <= w_bi * w_wi;
                r_p1_ri <= w_br * w_wi;
                r_p1_ir <= w_bi * w_wr;
            end
            if (w_vld[MEM_LATENCY+1]) begin
                r_p2_a   <= r_p1_a;
                r_p2_bwr <= w_bwr_rnd[c_PW-1:c_DW-1];
                r_p2_bwi <= w_bwi_rnd[c_PW-1:c_DW-1];
            end
        end
    end

    // Output stage only loads on a valid result, so idle cycles hold the last write.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_wraddr_a <= '0;
            r_wraddr_b <= '0;
            r_wrdata_a <= '0;
            r_wrdata_b <= '0;
            r_count    <= '0;
        end else if (w_vld[c_DEPTH-1]) begin
            r_wraddr_a <= r_addr_a[c_DEPTH-2];
            r_wraddr_b <= r_addr_b[c_DEPTH-2];
            r_wrdata_a <= {f_half_sat(r_p2_a[c_PW-1:c_DW], r_p2_bwr, 1'b0),
                           f_half_sat(r_p2_a[c_DW-1:0],    r_p2_bwi, 1'b0)};
            r_wrdata_b <= {f_half_sat(r_p2_a[c_PW-1:c_DW], r_p2_bwr, 1'b1),
                           f_half_sat(r_p2_a[c_DW-1:0],    r_p2_bwi, 1'b1)};
            r_count    <= r_count + 1'b1;
        end
    end

    assign bus.o_wren       = r_vld[c_DEPTH-1];
    assign bus.o_busy       = |r_vld;
    assign bus.o_wraddr_A   = r_wraddr_a;
    assign bus.o_wraddr_B   = r_wraddr_b;
    assign bus.o_wrdata_A   = r_wrdata_a;
    assign bus.o_wrdata_B   = r_wrdata_b;
    assign bus.o_bfly_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_butterfly_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_butterfly_stage
// Brief    : Directed self-checking bench for butterfly_stage (DW=16, latency 1).
// Revision : 1.0
// ============================================================================
module tb_butterfly_stage;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    butterfly_stage_if #(.ADDR_SIZE(AW), .DATA_WIDTH(DW), .CNT_SIZE(CW)) bus ();

    butterfly_stage #(
        .ADDR_SIZE(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1), .CNT_SIZE(CW)
    ) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [2*DW-1:0] p_a = '0, p_b = '0, p_w = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: data of the previous issue goes out now (memory latency 1).
    task automatic step(input logic rd, input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                        input logic [2*DW-1:0] da, input logic [2*DW-1:0] db,
                        input logic [2*DW-1:0] tw);
        bus.i_data_A   = p_a;
        bus.i_data_B   = p_b;
        bus.i_twiddle  = p_w;
        bus.i_rden     = rd;
        bus.i_rdaddr_A = aa;
        bus.i_rdaddr_B = ab;
        p_a = da;
        p_b = db;
        p_w = tw;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, AW'($urandom), AW'($urandom), $urandom, $urandom, $urandom);
    endtask

    task automatic run_one(input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                           input logic [2*DW-1:0] da, input logic [2*DW-1:0] db,
                           input logic [2*DW-1:0] tw, input logic [2*DW-1:0] ex,
                           input logic [2*DW-1:0] ey, input logic [CW-1:0] cnt);
        step(1'b1, aa, ab, da, db, tw);
        idle();
        idle();
        chk("wren_t3", 64'(bus.o_wren), 64'd0);
        idle();
        chk("wren_t4", 64'(bus.o_wren), 64'd1);
        chk("busy_t4", 64'(bus.o_busy), 64'd1);
        chk("wraddr_A", 64'(bus.o_wraddr_A), 64'(aa));
        chk("wraddr_B", 64'(bus.o_wraddr_B), 64'(ab));
        chk("wrdata_A", 64'(bus.o_wrdata_A), 64'(ex));
        chk("wrdata_B", 64'(bus.o_wrdata_B), 64'(ey));
        chk("count", 64'(bus.o_bfly_count), 64'(cnt));
        idle();
        chk("wren_t5", 64'(bus.o_wren), 64'd0);
        chk("busy_t5", 64'(bus.o_busy), 64'd0);
        chk("hold_A", 64'(bus.o_wrdata_A), 64'(ex));
        chk("hold_addrB", 64'(bus.o_wraddr_B), 64'(ab));
    endtask

    logic            issue_tab [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [AW-1:0]   addr_tab  [6] = '{5'd0, 5'd2, 5'd4, 5'd6, 5'd0, 5'd8};

    initial begin
        rst            = 1'b1;
        bus.i_rden     = 1'b0;
        bus.i_rdaddr_A = '0;
        bus.i_rdaddr_B = '0;
        bus.i_data_A   = '0;
        bus.i_data_B   = '0;
        bus.i_twiddle  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wren", 64'(bus.o_wren), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_count", 64'(bus.o_bfly_count), 64'd0);
        chk("rst_addr", 64'({bus.o_wraddr_A, bus.o_wraddr_B}), 64'd0);
        chk("rst_data", 64'({bus.o_wrdata_A, bus.o_wrdata_B}), 64'd0);
        rst = 1'b0;

        run_one(5'd0, 5'd1, 32'h4000_0000, 32'h4000_0000, 32'h7FFF_0000,
                32'h4000_0000, 32'h0000_0000, 8'd1);
        run_one(5'd2, 5'd3, 32'h0000_0000, 32'h2000_0000, 32'h0000_8000,
                32'h0000_F000, 32'h0000_1000, 8'd2);
        run_one(5'd4, 5'd5, 32'h7FFF_0000, 32'h8000_8000, 32'h8000_7FFF,
                32'h7FFF_0001, 32'hC000_0000, 8'd3);
        run_one(5'd6, 5'd7, 32'h1234_8000, 32'h0000_0000, 32'h5A5A_A5A5,
                32'h091A_C000, 32'h091A_C000, 8'd4);

        // Burst of four, one gap, one more.
        for (int k = 0; k < 10; k++) begin
            if (k < 6 && issue_tab[k])
                step(1'b1, addr_tab[k], addr_tab[k] + 5'd1, '0, '0, '0);
            else
                idle();
            if (k >= 3) begin
                chk("burst_wren", 64'(bus.o_wren), 64'((k - 3 < 6) ? issue_tab[k-3] : 1'b0));
                if (k - 3 < 6 && issue_tab[k-3]) begin
                    chk("burst_addrA", 64'(bus.o_wraddr_A), 64'(addr_tab[k-3]));
                    chk("burst_addrB", 64'(bus.o_wraddr_B), 64'(addr_tab[k-3] + 5'd1));
                end
            end
        end
        chk("burst_count", 64'(bus.o_bfly_count), 64'd9);
        chk("burst_busy", 64'(bus.o_busy), 64'd0);

        // Reset while a butterfly is in flight.
        step(1'b1, 5'd10, 5'd11, 32'h1000_1000, 32'h1000_1000, 32'h7FFF_0000);
        idle();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(bus.o_busy), 64'd0);
        chk("midrst_count", 64'(bus.o_bfly_count), 64'd0);
        idle();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("midrst_wren", 64'(bus.o_wren), 64'd0);
            idle();
        end
        chk("midrst_count_end", 64'(bus.o_bfly_count), 64'd0);

        // 257 back-to-back issues: counter wraps after the 256th result.
        for (int k = 0; k < 260; k++) begin
            if (k < 257)
                step(1'b1, AW'(k), AW'(k + 1), 32'(k), '0, '0);
            else
                idle();
            if (k == 257) chk("wrap_cnt255", 64'(bus.o_bfly_count), 64'd255);
            if (k == 258) chk("wrap_cnt0", 64'(bus.o_bfly_count), 64'd0);
            if (k == 259) begin
                chk("wrap_cnt1", 64'(bus.o_bfly_count), 64'd1);
                chk("wrap_wren", 64'(bus.o_wren), 64'd1);
                chk("wrap_addrA", 64'(bus.o_wraddr_A), 64'(AW'(256)));
            end
        end
        idle();
        chk("wrap_done", 64'(bus.o_wren), 64'd0);
        chk("wrap_hold", 64'(bus.o_bfly_count), 64'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
